// File: rtl/mult_operand_bank_if.sv
// Operand bank bus: loader/consumer side signals of mult_operand_bank.
// The master drives enqueue/consume requests; the slave (the bank) reports
// head operand, occupancy and sticky error flags.
interface mult_operand_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clear;
  logic [WIDTH-1:0] data_in;
  logic             Write;
  logic             wr_ready;
  logic             Read;
  logic             recycle;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             udf;

  modport master (
    output clear, data_in, Write, Read, recycle,
    input  wr_ready, out, out_valid, count, ovf, udf
  );

  modport slave (
    input  clear, data_in, Write, Read, recycle,
    output wr_ready, out, out_valid, count, ovf, udf
  );
endinterface

// File: rtl/mult_operand_bank.sv
// Show-ahead operand FIFO feeding the multiplier. Supports a recycle read that
// re-appends the popped head at the tail, a synchronous flush and sticky
// overflow/underflow flags. All outputs derive from registered state only.
module mult_operand_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mult_operand_bank_if.slave      bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             udf_q;

  logic full;
  logic empty;
  logic rd_acc;
  logic rcy_acc;
  logic plain_rd;
  logic wr_acc;

  // Accept decisions, all taken from pre-edge state.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    rd_acc   = bus.Read & ~empty;
    rcy_acc  = rd_acc & bus.recycle;
    plain_rd = rd_acc & ~bus.recycle;
    // A recycle read owns the tail slot this cycle, so a concurrent write loses.
    wr_acc   = bus.Write & ~full & ~rcy_acc;
  end

  // Operand storage; not reset, and left untouched by clear.
  always_ff @(posedge clk) begin
    if (!bus.clear) begin
      if (rcy_acc)
        mem[wr_ptr] <= mem[rd_ptr];
      else if (wr_acc)
        mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (rd_acc)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_acc || rcy_acc)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (wr_acc && !plain_rd)
        count_q <= count_q + CNT_W'(1);
      else if (plain_rd && !wr_acc)
        count_q <= count_q - CNT_W'(1);
    end
  end

  // Sticky error flags: dropped write and read-while-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.clear) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.Write && (full || rcy_acc))
        ovf_q <= 1'b1;
      if (bus.Read && empty)
        udf_q <= 1'b1;
    end
  end

  // Registered-state outputs; head reads as zero when empty.
  always_comb begin
    bus.out       = empty ? '0 : mem[rd_ptr];
    bus.out_valid = ~empty;
    bus.wr_ready  = ~full;
    bus.count     = count_q;
    bus.ovf       = ovf_q;
    bus.udf       = udf_q;
  end
endmodule

// File: tb/tb_mult_operand_bank.sv
// Directed bench for mult_operand_bank (WIDTH=8, DEPTH=4): fill/drain,
// overflow, underflow, recycle, pointer wrap, async reset and clear.
module tb_mult_operand_bank;
  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;

  mult_operand_bank_if #(.WIDTH(8), .DEPTH(4)) bus ();

  mult_operand_bank #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request levels; returns 1 time unit after the edge.
  task automatic cyc(input logic cl, input logic w, input logic [7:0] d,
                     input logic r, input logic rc);
    bus.clear   = cl;
    bus.Write   = w;
    bus.data_in = d;
    bus.Read    = r;
    bus.recycle = rc;
    @(posedge clk);
    #1;
    bus.clear   = 1'b0;
    bus.Write   = 1'b0;
    bus.Read    = 1'b0;
    bus.recycle = 1'b0;
    bus.data_in = '0;
  endtask

  initial begin
    logic [7:0] fill [4];
    logic [7:0] exp_head;
    n_checks = 0;
    n_fail   = 0;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    rst = 1'b1;
    bus.clear = 1'b0; bus.Write = 1'b0; bus.Read = 1'b0;
    bus.recycle = 1'b0; bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count), 0);
    check("rst_out", 32'(bus.out), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_wr_ready", 32'(bus.wr_ready), 1);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_udf", 32'(bus.udf), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill: first write shows up on out after one edge.
    cyc(0, 1, fill[0], 0, 0);
    check("first_out", 32'(bus.out), 32'h11);
    check("first_valid", 32'(bus.out_valid), 1);
    for (int i = 1; i < 4; i++) cyc(0, 1, fill[i], 0, 0);
    check("full_count", 32'(bus.count), 4);
    check("full_wr_ready", 32'(bus.wr_ready), 0);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check("drain_head", 32'(bus.out), 32'(fill[i]));
      cyc(0, 0, 8'h00, 1, 0);
    end
    check("drain_out", 32'(bus.out), 0);
    check("drain_valid", 32'(bus.out_valid), 0);
    check("drain_count", 32'(bus.count), 0);

    // Overflow: write while full with a read in the same cycle is dropped.
    for (int i = 0; i < 4; i++) cyc(0, 1, fill[i], 0, 0);
    cyc(0, 1, 8'h55, 1, 0);
    check("ovf_count", 32'(bus.count), 3);
    check("ovf_flag", 32'(bus.ovf), 1);
    check("ovf_head", 32'(bus.out), 32'h22);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    check("ovf_sticky", 32'(bus.ovf), 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1, 0);
    check("no_55_stored", 32'(bus.out_valid), 0);
    cyc(1, 0, 8'h00, 0, 0);
    check("clr_ovf", 32'(bus.ovf), 0);
    check("clr_count", 32'(bus.count), 0);

    // Underflow: read+write on empty accepts the write, flags the read.
    cyc(0, 1, 8'h7A, 1, 0);
    check("udf_flag", 32'(bus.udf), 1);
    check("udf_count", 32'(bus.count), 1);
    check("udf_out", 32'(bus.out), 32'h7A);
    check("udf_no_ovf", 32'(bus.ovf), 0);
    cyc(1, 0, 8'h00, 0, 0);
    check("clr_udf", 32'(bus.udf), 0);

    // Recycle: 8 recycle reads cycle the full bank; a concurrent write is dropped.
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'(i + 1), 0, 0);
    for (int i = 0; i < 8; i++) begin
      exp_head = 8'((i % 4) + 1);
      check("rcy_head", 32'(bus.out), 32'(exp_head));
      cyc(0, (i == 2), 8'h99, 1, 1);
      check("rcy_count", 32'(bus.count), 4);
    end
    check("rcy_wrap_head", 32'(bus.out), 32'h01);
    check("rcy_ovf", 32'(bus.ovf), 1);
    cyc(0, 0, 8'h00, 0, 1);
    check("recycle_alone", 32'(bus.out), 32'h01);
    cyc(1, 0, 8'h00, 0, 0);

    // Pointer wrap with count held at 2.
    cyc(0, 1, 8'hA0, 0, 0);
    cyc(0, 1, 8'hA1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      check("wrap_head", 32'(bus.out), 32'(8'hA0 + 8'(k)));
      cyc(0, 1, 8'hA2 + 8'(k), 1, 0);
      check("wrap_count", 32'(bus.count), 2);
    end
    check("wrap_final", 32'(bus.out), 32'hAA);
    cyc(1, 0, 8'h00, 0, 0);

    // Async reset mid-cycle at count 3 with udf set.
    cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'hB1 + 8'(i), 0, 0);
    check("pre_rst_count", 32'(bus.count), 3);
    check("pre_rst_udf", 32'(bus.udf), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(bus.count), 0);
    check("arst_out", 32'(bus.out), 0);
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_udf", 32'(bus.udf), 0);
    check("arst_ovf", 32'(bus.ovf), 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 1, 8'hC5, 0, 0);
    check("post_rst_out", 32'(bus.out), 32'hC5);
    cyc(1, 1, 8'hD6, 0, 0);
    check("clr_wr_count", 32'(bus.count), 0);
    check("clr_wr_out", 32'(bus.out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
